// File: rtl/tart_iddr_pkg.sv
// Shared definitions for the IDDR2 phase-selection block.
// Contents: FSM state encoding, IDDR reset pulse length, default generics.
package tart_iddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DECIDE  = 3'd4,
        ST_LOCKED  = 3'd5
    } state_e;

    // Length of the IDDR2 R pulse in clk_i cycles.
    localparam int IDDR_RST_CYCLES = 2;

    localparam int DEF_WINDOW = 256;
    localparam int DEF_SETTLE = 4;
    localparam int DEF_CWIDTH = 9;

endpackage

// File: rtl/trans_counter.sv
// Saturating, clearable, enable-gated event counter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : clear to zero (wins over counting)
//   en_i         : counting window open
//   inc_i        : event this cycle
//   cnt_o        : current count, sticks at all-ones
module trans_counter
    import tart_iddr_pkg::*;
#(
    parameter int CWIDTH = DEF_CWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              inc_i,
    output logic [CWIDTH-1:0] cnt_o
);

    localparam logic [CWIDTH-1:0] CNT_MAX = '1;

    logic [CWIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/iddr_phase_ctrl.sv
// Sequencer and phase selector for one IDDR2 capture primitive.
// Resets/enables the IDDR2, counts data transitions in each half-cycle
// interval over a window, then forwards whichever of Q0/Q1 samples furthest
// from the transitions.
// Ports:
//   clk_i, rst_i        : clock (also IDDR2 C0), synchronous active-high reset
//   start_i             : pulse, (re)starts calibration from any state
//   q0_i, q1_i          : IDDR2 rising / falling edge samples
//   iddr_rst_o, iddr_ce_o : IDDR2 R and CE
//   data_o, valid_o     : selected stream, valid while locked
//   phase_o             : 0 = Q0, 1 = Q1
//   locked_o, busy_o, err_o : status (err sticky until start/reset)
module iddr_phase_ctrl
    import tart_iddr_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int SETTLE = DEF_SETTLE,
    parameter int CWIDTH = DEF_CWIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic q0_i,
    input  logic q1_i,
    output logic iddr_rst_o,
    output logic iddr_ce_o,
    output logic data_o,
    output logic valid_o,
    output logic phase_o,
    output logic locked_o,
    output logic busy_o,
    output logic err_o
);

    // One shared down-the-phase timer covers RESET, SETTLE and MEASURE.
    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] RST_LAST = TW'(IDDR_RST_CYCLES - 1);
    localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);

    state_e            state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              r0_q, r0_d, r1_q, r1_d, p1_q, p1_d;
    logic              iddr_rst_q, iddr_rst_d;
    logic              iddr_ce_q, iddr_ce_d;
    logic              phase_q, phase_d;
    logic              locked_q, locked_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              cnt_clr, cnt_en, inc0, inc1;
    logic [CWIDTH-1:0] t0, t1;

    // t0: transition between previous Q1 sample and this Q0 sample.
    // p1 is stale on the first window cycle, so that term is dropped there.
    assign inc0 = (r0_q != p1_q) && (tmr_q != '0);
    // t1: transition between this Q0 sample and this Q1 sample.
    assign inc1 = (r1_q != r0_q);

    trans_counter #(.CWIDTH(CWIDTH)) u_t0 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .inc_i (inc0),
        .cnt_o (t0)
    );

    trans_counter #(.CWIDTH(CWIDTH)) u_t1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .inc_i (inc1),
        .cnt_o (t1)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        phase_d = phase_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        r0_d    = q0_i;
        r1_d    = q1_i;
        p1_d    = r1_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_RESET: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                cnt_clr = 1'b1;
                if (tmr_q == SET_LAST) begin
                    state_d = ST_MEASURE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                cnt_en = 1'b1;
                if (tmr_q == WIN_LAST) begin
                    state_d = ST_DECIDE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DECIDE: begin
                // Separate zero tests avoid an overflowing t0+t1.
                if ((t0 == '0) && (t1 == '0)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Strict compare: ties keep Q0.
                    phase_d = (t0 > t1);
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: ;
            default: state_d = ST_IDLE;
        endcase

        if (start_i) begin
            state_d = ST_RESET;
            tmr_d   = '0;
            err_d   = 1'b0;
            cnt_clr = 1'b1;
        end

        // Outputs are decoded from the next state so they leave a flop.
        iddr_rst_d = (state_d == ST_RESET);
        iddr_ce_d  = (state_d == ST_SETTLE) || (state_d == ST_MEASURE) ||
                     (state_d == ST_DECIDE) || (state_d == ST_LOCKED);
        locked_d   = (state_d == ST_LOCKED);
        busy_d     = (state_d == ST_RESET) || (state_d == ST_SETTLE) ||
                     (state_d == ST_MEASURE) || (state_d == ST_DECIDE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            r0_q       <= 1'b0;
            r1_q       <= 1'b0;
            p1_q       <= 1'b0;
            iddr_rst_q <= 1'b0;
            iddr_ce_q  <= 1'b0;
            phase_q    <= 1'b0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            p1_q       <= p1_d;
            iddr_rst_q <= iddr_rst_d;
            iddr_ce_q  <= iddr_ce_d;
            phase_q    <= phase_d;
            locked_q   <= locked_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign iddr_rst_o = iddr_rst_q;
    assign iddr_ce_o  = iddr_ce_q;
    assign phase_o    = phase_q;
    assign locked_o   = locked_q;
    assign valid_o    = locked_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
    assign data_o     = locked_q & (phase_q ? r1_q : r0_q);

endmodule

// File: tb/tb_iddr_phase_ctrl.sv
module tb_iddr_phase_ctrl;

    localparam int W    = 256;
    localparam int S    = 4;
    localparam int CW   = 9;
    localparam int W2   = 16;
    localparam int S2   = 2;
    localparam int CW2  = 4;
    localparam int LAT  = 2 + S + W + 2;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_i, start_i, start2, q0_i, q1_i;
    logic iddr_rst_o, iddr_ce_o, data_o, valid_o, phase_o, locked_o, busy_o, err_o;
    logic iddr_rst2, ce2, data2, valid2, phase2, locked2, busy2, err2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    iddr_phase_ctrl #(.WINDOW(W), .SETTLE(S), .CWIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .q0_i(q0_i), .q1_i(q1_i),
        .iddr_rst_o(iddr_rst_o), .iddr_ce_o(iddr_ce_o), .data_o(data_o),
        .valid_o(valid_o), .phase_o(phase_o), .locked_o(locked_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Small instance with an undersized counter to exercise saturation.
    iddr_phase_ctrl #(.WINDOW(W2), .SETTLE(S2), .CWIDTH(CW2)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start2), .q0_i(q0_i), .q1_i(q1_i),
        .iddr_rst_o(iddr_rst2), .iddr_ce_o(ce2), .data_o(data2),
        .valid_o(valid2), .phase_o(phase2), .locked_o(locked2),
        .busy_o(busy2), .err_o(err2)
    );

    typedef struct {
        bit err;
        bit ph;
        int at;
    } ev_t;

    ev_t evq[$];
    bit  dq[$];

    // Input history and per-cycle expected status levels.
    bit q0h[MAXC], q1h[MAXC];
    bit e_rst[MAXC], e_busy[MAXC], e_lock[MAXC], e_err[MAXC], e_ph[MAXC];

    // Reference model state.
    int st_n   = -100000;
    bit m_lock = 0, m_err = 0, m_ph = 0;
    int ev_at  = -1;
    bit ev_err = 0, ev_ph = 0;
    int last_lock = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and derive what the next cycle must show.
    task automatic step(input bit a0, input bit a1, input bit st, input bit rs);
        int c, d;
        @(posedge clk);
        #1;
        q0_i = a0; q1_i = a1; start_i = st; rst_i = rs;
        c = cyc;
        if (c + 1 >= MAXC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", c, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        q0h[c] = a0;
        q1h[c] = a1;
        if (rs) begin
            st_n = -100000; m_lock = 0; m_err = 0; m_ph = 0; ev_at = -1;
        end else if (st) begin
            st_n = c; m_lock = 0; m_err = 0; ev_at = -1;
        end else if (ev_at == c + 1) begin
            if (ev_err) m_err = 1;
            else begin m_lock = 1; m_ph = ev_ph; end
            ev_at = -1;
        end
        d = c + 1 - st_n;
        e_rst[c+1]  = (d >= 1) && (d <= 2);
        e_busy[c+1] = (d >= 1) && (d <= 3 + S + W);
        e_lock[c+1] = m_lock;
        e_err[c+1]  = m_err;
        e_ph[c+1]   = m_ph;
        if (m_lock) dq.push_back(m_ph ? a1 : a0);
    endtask

    function automatic void gen(input int mode, input int k, input int ofs,
                                output bit b0, output bit b1);
        bit t;
        t = ((k + ofs) & 1) != 0;
        case (mode)
            0: begin b0 = t; b1 = t; end           // change at every rising edge
            1: begin b0 = t; b1 = ~t; end          // change only between Q0 and Q1
            2: begin b0 = 1'b1; b1 = 1'b1; end     // no activity
            3: begin b0 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1)); end
            4: begin b0 = t; b1 = 1'b1; end        // balanced: ties
            default: begin
                b1 = 1'($urandom_range(0, 1));
                b0 = ($urandom_range(0, 7) == 0) ? ~b1 : b1;
            end
        endcase
    endfunction

    // Count transitions straight from the sampled history and schedule the outcome.
    task automatic decide(input int a);
        int  t0 = 0, t1 = 0;
        int  smax = (1 << CW) - 1;
        ev_t e;
        for (int i = a; i < a + W; i++) begin
            if (q0h[i] != q1h[i]) t1++;
            if (i > a && q0h[i] != q1h[i-1]) t0++;
        end
        if (t0 > smax) t0 = smax;
        if (t1 > smax) t1 = smax;
        e.at  = a + W + 2;
        e.err = (t0 + t1 == 0);
        e.ph  = e.err ? m_ph : (t0 > t1);
        evq.push_back(e);
        ev_at = e.at; ev_err = e.err; ev_ph = e.ph;
    endtask

    task automatic calib(input int mode, input int abort_at, output int n);
        int a, ofs;
        bit b0, b1;
        ofs = $urandom_range(0, 1);
        gen(mode, -(2 + S), ofs, b0, b1);
        step(b0, b1, 1, 0);
        n = cyc;
        a = n + 2 + S;      // first input cycle seen by the measurement window
        for (int c = n + 1; c < a + W; c++) begin
            if (abort_at >= 0 && c == a + abort_at) return;
            gen(mode, c - a, ofs, b0, b1);
            step(b0, b1, 0, 0);
        end
        decide(a);
    endtask

    task automatic tail(input int k);
        repeat (k) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    endtask

    // Monitor: per-cycle status levels, data scoreboard, completion events.
    bit lk_prev = 0, er_prev = 0;
    always @(negedge clk) begin : mon
        int  c;
        ev_t e;
        c = cyc;
        if (c > 0 && c < MAXC) begin
            chk("iddr_rst", iddr_rst_o, e_rst[c]);
            chk("busy", busy_o, e_busy[c]);
            chk("locked", locked_o, e_lock[c]);
            chk("valid", valid_o, e_lock[c]);
            chk("err", err_o, e_err[c]);
            chk("phase", phase_o, e_ph[c]);
            if (valid_o === 1'b1) begin
                if (dq.size() == 0) chk("data_unexpected", 1, 0);
                else chk("data", data_o, dq.pop_front());
            end
            if ((locked_o === 1'b1 && !lk_prev) || (err_o === 1'b1 && !er_prev)) begin
                if (locked_o === 1'b1) last_lock = c;
                if (evq.size() == 0) chk("event_unexpected", 1, 0);
                else begin
                    e = evq.pop_front();
                    chk("ev_err", err_o, e.err);
                    chk("ev_phase", phase_o, e.ph);
                    chk("ev_cycle", c, e.at);
                end
            end
            lk_prev = (locked_o === 1'b1);
            er_prev = (err_o === 1'b1);
        end
    end

    initial begin
        int n, n2;
        rst_i = 1'b1; start_i = 1'b1; start2 = 1'b0; q0_i = 1'b0; q1_i = 1'b0;

        // Reset held with start asserted: everything stays at zero.
        repeat (3) step(0, 0, 1, 1);
        chk("rst_iddr_rst", iddr_rst_o, 0);
        chk("rst_ce", iddr_ce_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_phase", phase_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        repeat (6) step(0, 0, 0, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_ce", iddr_ce_o, 0);

        // Q1 selection, then lock latency.
        calib(0, -1, n);
        tail(20);
        chk("q1_phase", phase_o, 1);
        chk("q1_locked", locked_o, 1);
        chk("q1_ce", iddr_ce_o, 1);
        chk("q1_latency", last_lock - n, LAT);

        // No activity: error, phase kept.
        calib(2, -1, n);
        tail(10);
        chk("idle_err", err_o, 1);
        chk("idle_locked", locked_o, 0);
        chk("idle_phase_kept", phase_o, 1);
        chk("idle_after_err_busy", busy_o, 0);

        // Q0 selection.
        calib(1, -1, n);
        tail(20);
        chk("q0_phase", phase_o, 0);
        chk("q0_locked", locked_o, 1);

        // Restart 100 cycles into the window.
        calib(0, 100, n);
        calib(0, -1, n);
        tail(8);
        chk("restart_latency", last_lock - n, LAT);
        chk("restart_phase", phase_o, 1);

        // Tie between intervals.
        calib(4, -1, n);
        tail(10);
        chk("tie_phase", phase_o, 0);

        // Randomized calibrations.
        repeat (8) begin
            calib(int'($urandom_range(0, 5)), -1, n);
            tail(int'($urandom_range(3, 25)));
        end

        // Reset in the middle of a measurement.
        calib(3, 60, n);
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_phase", phase_o, 0);
        chk("midrst_ce", iddr_ce_o, 0);

        // Saturation on the small instance: t1 would reach 16, t0 = 15.
        step(0, 1, 0, 0);
        start2 = 1'b1;
        n2 = cyc;
        step(0, 1, 0, 0);
        start2 = 1'b0;
        while (cyc < n2 + 2 + S2 + W2 + 1) step(0, 1, 0, 0);
        chk("sat_not_yet_locked", locked2, 0);
        step(0, 1, 0, 0);
        chk("sat_locked", locked2, 1);
        chk("sat_phase", phase2, 0);
        chk("sat_err", err2, 0);
        chk("sat_data", data2, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("data_queue_drained", dq.size(), 0);
        chk("event_queue_drained", evq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
